// File: rtl/debounce_pkg.sv
// Shared defaults and the counter-width helper for the debounce bank.
// DEBOUNCE_AUTOREPEAT_EN adds the auto-repeat defaults.
package debounce_pkg;

  localparam int DEFAULT_NUM_CH     = 4;
  localparam int DEFAULT_STABLE_CNT = 8192;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int DEFAULT_REPEAT_DELAY = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE  = 5_000_000;
`endif

  // Never returns less than 1 so that tiny counts still get a real register.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and
// pulse registers. DEBOUNCE_AUTOREPEAT_EN adds a held-press repeat counter.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int   CNT_W      = cnt_width(STABLE_CNT),
  parameter logic IDLE_LEVEL = 1'b0
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int   REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int   REPEAT_RATE  = DEFAULT_REPEAT_RATE
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             cand;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             rpt_fire;

  // A new level is taken only once the candidate has survived the full window.
  assign accept = (sync_q == cand) && (count == CNT_LAST) && (level != cand);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta     <= IDLE_LEVEL;
      sync_q        <= IDLE_LEVEL;
      cand          <= IDLE_LEVEL;
      count         <= '0;
      level         <= IDLE_LEVEL;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      if (sync_q != cand) begin
        cand  <= sync_q;
        count <= '0;
      end else if (count != CNT_LAST) begin
        count <= count + CNT_W'(1);
      end
      if (accept) begin
        level <= cand;
      end
      press_pulse   <= (accept && (cand != IDLE_LEVEL)) || rpt_fire;
      release_pulse <= accept && (cand == IDLE_LEVEL);
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_phase;
  logic [RPT_W-1:0] rpt_last;

  assign rpt_last = rpt_phase ? RATE_LAST : DELAY_LAST;
  // Suppressed on the release edge so a repeat never lands on release_pulse.
  assign rpt_fire = (level != IDLE_LEVEL) && !accept && (rpt_cnt == rpt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if ((level == IDLE_LEVEL) || accept) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent debounce channels with clean levels and press/release
// pulses. Define DEBOUNCE_AUTOREPEAT_EN to add auto-repeat on held presses.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   NUM_CH     = DEFAULT_NUM_CH,
  parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int   CNT_W      = cnt_width(STABLE_CNT),
  parameter logic IDLE_LEVEL = 1'b0
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int   REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
  parameter int   REPEAT_RATE  = DEFAULT_REPEAT_RATE
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT   (STABLE_CNT),
      .CNT_W        (CNT_W),
      .IDLE_LEVEL   (IDLE_LEVEL)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
`endif
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn_in[i]),
      .level         (level_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: a sample-window model predicts each
// cycle's level and pulses; a negedge monitor pops and compares them.
module tb_debounce_bank;

  localparam int   NUM_CH     = 4;
  localparam int   STABLE_CNT = 4;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int   REPEAT_DELAY = 10;
  localparam int   REPEAT_RATE  = 5;
`endif
  localparam int WIN = STABLE_CNT + 1;
  localparam logic [NUM_CH-1:0] IDLE_VEC = {NUM_CH{IDLE_LEVEL}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] btn_in = IDLE_VEC;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] press_pulse;
  logic [NUM_CH-1:0] release_pulse;

  debounce_bank #(
    .NUM_CH       (NUM_CH),
    .STABLE_CNT   (STABLE_CNT),
    .IDLE_LEVEL   (IDLE_LEVEL)
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] rel;
  } exp_t;

  exp_t              sb [$];
  logic [NUM_CH-1:0] hist [$];
  logic [NUM_CH-1:0] mlevel = IDLE_VEC;
  int                press_edge [NUM_CH];
  int                ecnt = 0;
  int                checks = 0;
  int                errors = 0;
  int                pulses_seen = 0;

  task automatic checkOutput(input string name, input logic [NUM_CH-1:0] act,
                             input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s edge %0d got %b expected %b", name, ecnt, act, exp);
    end
  endtask

  // Reference model: a channel takes value v at edge e once the raw pin held v
  // in the STABLE_CNT+1 samples taken at edges e-2-STABLE_CNT .. e-2.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sb.delete();
        hist.delete();
        ecnt   = 0;
        mlevel = IDLE_VEC;
      end else begin
        exp_t e;
        ecnt++;
        if (ecnt == 1) begin
          for (int k = 1; k <= 2; k++) sb.push_back('{k, IDLE_VEC, '0, '0});
          for (int k = 0; k < WIN; k++) hist.push_back(IDLE_VEC);
        end
        hist.push_back(btn_in);
        void'(hist.pop_front());
        e.cyc   = ecnt + 2;
        e.press = '0;
        e.rel   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          logic v;
          logic steady;
          v = hist[0][c];
          steady = 1'b1;
          for (int j = 1; j < WIN; j++) if (hist[j][c] != v) steady = 1'b0;
          if (steady && (v != mlevel[c])) begin
            mlevel[c] = v;
            if (v != IDLE_LEVEL) begin
              e.press[c]    = 1'b1;
              press_edge[c] = e.cyc;
            end else begin
              e.rel[c] = 1'b1;
            end
          end
`ifdef DEBOUNCE_AUTOREPEAT_EN
          else if (mlevel[c] != IDLE_LEVEL) begin
            int d;
            d = e.cyc - press_edge[c];
            if ((d >= REPEAT_DELAY) && (((d - REPEAT_DELAY) % REPEAT_RATE) == 0))
              e.press[c] = 1'b1;
          end
`endif
        end
        e.level = mlevel;
        sb.push_back(e);
      end
    end
  end

  // Monitor: reset values while no edge has run, otherwise pop the prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || (ecnt == 0)) begin
        checkOutput("reset_level", level_out, IDLE_VEC);
        checkOutput("reset_press", press_pulse, '0);
        checkOutput("reset_release", release_pulse, '0);
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty edge %0d", ecnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.cyc != ecnt) begin
          errors++;
          $display("[TB] FAIL scoreboard_order got edge %0d expected %0d", e.cyc, ecnt);
        end
        checkOutput("level_out", level_out, e.level);
        checkOutput("press_pulse", press_pulse, e.press);
        checkOutput("release_pulse", release_pulse, e.rel);
        if ((press_pulse | release_pulse) != '0) pulses_seen++;
      end
    end
  end

  // Called #1 after a rising edge; holds v for n edges.
  task automatic applyStimulus(input logic [NUM_CH-1:0] v, input int n);
    btn_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input int n);
    rst    = 1'b1;
    btn_in = IDLE_VEC;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [NUM_CH-1:0] cur;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] idle after reset");
    applyStimulus(IDLE_VEC, 20);

    $display("[TB] single press and release on ch0");
    applyStimulus(4'b0001, 12);
    applyStimulus(4'b0000, 12);

    $display("[TB] bouncing ch1 then settle");
    for (int k = 0; k < 15; k++) applyStimulus((k % 2 == 0) ? 4'b0010 : 4'b0000, 2);
    applyStimulus(4'b0010, 12);
    applyStimulus(4'b0000, 12);

    $display("[TB] all channels together");
    applyStimulus(4'b1111, 12);
    applyStimulus(4'b0000, 12);

    $display("[TB] reset in the middle of a press");
    applyStimulus(4'b0100, 5);
    doReset(3);
    applyStimulus(IDLE_VEC, 20);

    $display("[TB] long hold on ch3");
    applyStimulus(4'b1000, 40);
    applyStimulus(4'b0000, 15);

    $display("[TB] randomized segments");
    cur = IDLE_VEC;
    for (int s = 0; s < 200; s++) begin
      int len;
      if ($urandom_range(0, 29) == 0) begin
        doReset($urandom_range(1, 3));
        cur = IDLE_VEC;
      end
      cur = cur ^ NUM_CH'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 35)
                                        : $urandom_range(1, 2 * STABLE_CNT + 2);
      applyStimulus(cur, len);
    end
    applyStimulus(IDLE_VEC, 20);

    checks++;
    if (pulses_seen == 0) begin
      errors++;
      $display("[TB] FAIL pulse_activity got 0 pulse cycles expected some");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
